bus_arbiter_rr: RTL and testbench

//  Round-robin arbiter/sequencer for the shared 16-bit 4:1 operand/bus mux in the multicycle datapath.
//  Up to four requesters (PC, ALU, memory, register-file writeback) compete for one shared consumer.

---
 rtl/arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 27 ++
 rtl/bus_arbiter_rr.sv | 145 ++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types, sizes and helpers for the round-robin bus arbiter.
package arb_pkg;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_e;

  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request at or above ptr (mod NREQ) wins.
module rr_pick
  import arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    any  = 1'b0;
    idx  = ptr;
    cand = ptr;
    // Walk from the farthest offset down so the nearest set bit overwrites the others.
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared 4:1 operand bus, with locked bursts.
// Define ARB_TIMEOUT_EN to abort a grant after TIMEOUT stalled cycles.
module bus_arbiter_rr
  import arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  lock,
  input  logic             bus_ready,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             bus_valid,
  output logic [NREQ-1:0]  ack,
  output logic             err,
  output logic [SEL_W-1:0] err_id
);

  arb_state_e       state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [3:0]       beat_q, beat_d;
  logic             bus_valid_q, bus_valid_d;
  logic [SEL_W-1:0] pick_ptr, pick_idx;
  logic             pick_any;
  logic             timeout;

  // On release the rotation restarts just past the owner, evaluated in the same cycle.
  assign pick_ptr = (state_q == ST_XFER) ? sel_q + SEL_W'(1) : ptr_q;

  rr_pick u_pick (
    .req (req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    beat_d      = beat_q;
    bus_valid_d = bus_valid_q;
    unique case (state_q)
      ST_IDLE: begin
        gnt_d       = '0;
        bus_valid_d = 1'b0;
        if (pick_any) begin
          state_d     = ST_XFER;
          gnt_d       = NREQ'(1) << pick_idx;
          sel_d       = pick_idx;
          bus_valid_d = 1'b1;
          beat_d      = '0;
        end
      end
      ST_XFER: begin
        if (timeout) begin
          state_d     = ST_IDLE;
          gnt_d       = '0;
          bus_valid_d = 1'b0;
          ptr_d       = sel_q + SEL_W'(1);
          beat_d      = '0;
        end else if (bus_ready) begin
          if (lock[sel_q] && req[sel_q] && ((32'(beat_q) + 32'd1) < MAX_BURST)) begin
            beat_d = beat_q + 4'd1;
          end else begin
            ptr_d  = sel_q + SEL_W'(1);
            beat_d = '0;
            if (pick_any) begin
              gnt_d = NREQ'(1) << pick_idx;
              sel_d = pick_idx;
            end else begin
              state_d     = ST_IDLE;
              gnt_d       = '0;
              bus_valid_d = 1'b0;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      sel_q       <= '0;
      ptr_q       <= '0;
      beat_q      <= '0;
      bus_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      beat_q      <= beat_d;
      bus_valid_q <= bus_valid_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0]       wait_q, wait_d;
  logic             err_q;
  logic [SEL_W-1:0] err_id_q, err_id_d;

  // Counter holds stalled cycles already elapsed; fire on the cycle that reaches TIMEOUT.
  assign timeout  = (state_q == ST_XFER) && !bus_ready &&
                    (({1'b0, wait_q} + 9'd1) == 9'(TIMEOUT));
  assign wait_d   = ((state_q == ST_XFER) && !bus_ready && !timeout) ? wait_q + 8'd1 : 8'd0;
  assign err_id_d = timeout ? onehot_to_idx(gnt_q) : err_id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q   <= '0;
      err_q    <= 1'b0;
      err_id_q <= '0;
    end else begin
      wait_q   <= wait_d;
      err_q    <= timeout;
      err_id_q <= err_id_d;
    end
  end

  assign err    = err_q;
  assign err_id = err_id_q;
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = TIMEOUT;
  assign timeout        = 1'b0;
  assign err            = 1'b0;
  assign err_id         = '0;
`endif

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign bus_valid = bus_valid_q;
  assign ack       = gnt_q & {NREQ{bus_valid_q & bus_ready}};

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: directed scenarios plus a randomized run
// against a rule-level reference model.
module tb_bus_arbiter_rr;

  localparam int MAXB = 4;
  localparam int TMO  = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, lock, gnt, ack;
  logic       bus_ready, bus_valid, err;
  logic [1:0] sel, err_id;

  int n_cmp = 0;
  int n_bad = 0;

  bus_arbiter_rr #(
    .MAX_BURST (MAXB),
    .TIMEOUT   (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .lock      (lock),
    .bus_ready (bus_ready),
    .gnt       (gnt),
    .sel       (sel),
    .bus_valid (bus_valid),
    .ack       (ack),
    .err       (err),
    .err_id    (err_id)
  );

  always #5 clk = ~clk;

  // First set request scanning upward from p, wrapping; -1 when none.
  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; lock = '0; bus_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk); #1;
    n_cmp++;
    if ({gnt, bus_valid} !== 5'b0100_1) begin
      n_bad++;
      $display("FAIL reset_pre: gnt/valid got %b/%b want 0100/1", gnt, bus_valid);
    end
    bus_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({gnt, sel, bus_valid, ack, err} !== 12'b0) begin
      n_bad++;
      $display("FAIL reset_async: gnt=%b sel=%b valid=%b ack=%b err=%b want all 0",
               gnt, sel, bus_valid, ack, err);
    end
    @(negedge clk);
    req = '0; bus_ready = 1'b0; rst_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if ({gnt, sel, bus_valid, ack} !== 11'b0) begin
      n_bad++;
      $display("FAIL reset_idle: gnt=%b sel=%b valid=%b ack=%b want all 0",
               gnt, sel, bus_valid, ack);
    end
  endtask

  task automatic test_single();
    logic [10:0] exp_s [5];
    exp_s = '{11'b0000_00_0_0000, 11'b0100_10_1_0000, 11'b0100_10_1_0000,
              11'b0100_10_1_0100, 11'b0000_10_0_0000};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req = (c < 3) ? 4'b0100 : 4'b0000;
      bus_ready = (c == 3);
      #1;
      n_cmp++;
      if ({gnt, sel, bus_valid, ack} !== exp_s[c]) begin
        n_bad++;
        $display("FAIL single c%0d: {gnt,sel,valid,ack} got %b want %b", c,
                 {gnt, sel, bus_valid, ack}, exp_s[c]);
      end
    end
  endtask

  task automatic test_fairness();
    logic [10:0] e;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req = 4'b1111; lock = '0; bus_ready = 1'b1;
      #1;
      if (c == 0) e = '0;
      else e = {4'(1 << ((c - 1) % 4)), 2'((c - 1) % 4), 1'b1, 4'(1 << ((c - 1) % 4))};
      n_cmp++;
      if ({gnt, sel, bus_valid, ack} !== e) begin
        n_bad++;
        $display("FAIL fairness c%0d: {gnt,sel,valid,ack} got %b want %b", c,
                 {gnt, sel, bus_valid, ack}, e);
      end
    end
  endtask

  task automatic test_burst_cap();
    logic [10:0] e;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req = 4'b0110; lock = 4'b0010; bus_ready = 1'b1;
      #1;
      if (c == 0) e = '0;
      else if (c <= MAXB) e = 11'b0010_01_1_0010;
      else e = 11'b0100_10_1_0100;
      n_cmp++;
      if ({gnt, sel, bus_valid, ack} !== e) begin
        n_bad++;
        $display("FAIL burst_cap c%0d: {gnt,sel,valid,ack} got %b want %b", c,
                 {gnt, sel, bus_valid, ack}, e);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      req = (c >= 3) ? 4'b1001 : 4'b0001;
      bus_ready = 1'b0;
      #1;
      if (c > 0) begin
        n_cmp++;
        if ({gnt, sel, bus_valid, ack} !== 11'b0001_00_1_0000) begin
          n_bad++;
          $display("FAIL stall c%0d: {gnt,sel,valid,ack} got %b want 00010010000", c,
                   {gnt, sel, bus_valid, ack});
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic [12:0] e;
    do_reset();
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      req = 4'b0100; bus_ready = 1'b0;
      #1;
`ifdef ARB_TIMEOUT_EN
      if (c == 0 || c > 17) continue;
      if (c <= TMO) e = {4'b0100, 1'b1, 4'b0000, 1'b0, 2'b00};
      else if (c == TMO + 1) e = {4'b0000, 1'b0, 4'b0000, 1'b1, 2'b10};
      else e = {4'b0100, 1'b1, 4'b0000, 1'b0, 2'b10};
      n_cmp++;
      if ({gnt, bus_valid, ack, err, err_id} !== e) begin
        n_bad++;
        $display("FAIL timeout c%0d: {gnt,valid,ack,err,err_id} got %b want %b", c,
                 {gnt, bus_valid, ack, err, err_id}, e);
      end
`else
      if (c == 0) continue;
      e = {4'b0100, 1'b1, 4'b0000, 1'b0, 2'b00};
      n_cmp++;
      if ({gnt, bus_valid, ack, err, err_id} !== e) begin
        n_bad++;
        $display("FAIL no_timeout c%0d: {gnt,valid,ack,err,err_id} got %b want %b", c,
                 {gnt, bus_valid, ack, err, err_id}, e);
      end
`endif
    end
  endtask

  task automatic test_random();
    bit         m_busy, m_err;
    int         m_owner, m_ptr, m_sel, m_beats, m_wait, m_err_id, w;
    logic [3:0] e_gnt, e_ack;
    do_reset();
    m_busy = 0; m_err = 0; m_owner = 0; m_ptr = 0; m_sel = 0;
    m_beats = 0; m_wait = 0; m_err_id = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      // Cycles 200..299 stall heavily so aborts get exercised when enabled.
      bus_ready = (c / 100 == 2) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        if (req[i]) begin
          if (m_busy && bus_ready && m_owner == i && $urandom_range(0, 1) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
        end
      end
      lock  = 4'($urandom);
      e_gnt = m_busy ? 4'(1 << m_owner) : 4'b0000;
      e_ack = (m_busy && bus_ready) ? e_gnt : 4'b0000;
      #1;
      n_cmp++;
      if ({gnt, sel, bus_valid, ack, err} !== {e_gnt, 2'(m_sel), m_busy, e_ack, m_err}) begin
        n_bad++;
        $display("FAIL random c%0d: {gnt,sel,valid,ack,err} got %b want %b", c,
                 {gnt, sel, bus_valid, ack, err}, {e_gnt, 2'(m_sel), m_busy, e_ack, m_err});
      end
      if (m_err) begin
        n_cmp++;
        if (err_id !== 2'(m_err_id)) begin
          n_bad++;
          $display("FAIL random_err_id c%0d: got %0d want %0d", c, err_id, m_err_id);
        end
      end
      m_err = 0;
      if (!m_busy) begin
        w = pick(req, m_ptr);
        if (w >= 0) begin
          m_busy = 1; m_owner = w; m_sel = w; m_beats = 0; m_wait = 0;
        end
      end else if (bus_ready) begin
        m_beats++;
        m_wait = 0;
        if (!(lock[m_owner] && req[m_owner] && m_beats < MAXB)) begin
          m_ptr = (m_owner + 1) % 4;
          m_beats = 0;
          w = pick(req, m_ptr);
          if (w >= 0) begin
            m_owner = w; m_sel = w;
          end else begin
            m_busy = 0;
          end
        end
      end else begin
        m_wait++;
`ifdef ARB_TIMEOUT_EN
        if (m_wait == TMO) begin
          m_busy = 0; m_err = 1; m_err_id = m_owner;
          m_ptr = (m_owner + 1) % 4; m_beats = 0; m_wait = 0;
        end
`endif
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; lock = '0; bus_ready = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_burst_cap();
    test_stall();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
